// File: rtl/request_arbiter.sv
// request_arbiter: upstream stage of the cache front end.
// Holds one AR, one AW and one W request, arbitrates read vs write
// round-robin and presents the winner as a packed 128-bit word on a
// one-entry registered valid/ready output.
module request_arbiter #(
  parameter logic FIRST_PRIO = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         arvalid,
  output logic         arready,
  input  logic [31:0]  araddr,
  input  logic [3:0]   arid,
  input  logic [1:0]   arburst,
  input  logic [2:0]   arsize,
  input  logic [7:0]   arlen,
  input  logic         awvalid,
  output logic         awready,
  input  logic [31:0]  awaddr,
  input  logic [3:0]   awid,
  input  logic [1:0]   awburst,
  input  logic [2:0]   awsize,
  input  logic [7:0]   awlen,
  input  logic         wvalid,
  output logic         wready,
  input  logic [63:0]  wdata,
  input  logic [7:0]   wstrb,
  output logic         result_valid,
  input  logic         result_ready,
  output logic [127:0] result_arb,
  output logic         read_or_write
);

  logic        ar_full;
  logic [31:0] ar_addr;
  logic [3:0]  ar_id;
  logic [1:0]  ar_burst;
  logic [2:0]  ar_size;
  logic [7:0]  ar_len;

  logic        aw_full;
  logic [31:0] aw_addr;
  logic [3:0]  aw_id;
  logic [1:0]  aw_burst;
  logic [2:0]  aw_size;
  logic [7:0]  aw_len;

  logic        w_full;
  logic [63:0] w_data;
  logic [7:0]  w_strb;

  // last_grant: 0 = read won the previous load, 1 = write did
  logic        last_grant;

  logic         read_elig;
  logic         write_elig;
  logic         out_free;
  logic         load;
  logic         grant_write;
  logic [127:0] read_word;
  logic [127:0] write_word;

  // Ready depends only on the holding flags, so a slot is never refilled
  // in the same cycle it drains.
  assign arready = !ar_full;
  assign awready = !aw_full;
  assign wready  = !w_full;

  // Eligibility, round-robin grant and packing of both candidate words.
  always_comb begin
    read_elig   = ar_full;
    write_elig  = aw_full && w_full;
    out_free    = !result_valid || result_ready;
    load        = out_free && (read_elig || write_elig);
    grant_write = write_elig && (!read_elig || !last_grant);
    read_word   = {79'd0, ar_addr, ar_id, ar_burst, ar_size, ar_len};
    write_word  = {7'd0, aw_addr, aw_id, aw_burst, aw_size, aw_len,
                   w_data, w_strb};
  end

  // AR holding register: capture on handshake, drain when read is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_full  <= 1'b0;
      ar_addr  <= '0;
      ar_id    <= '0;
      ar_burst <= '0;
      ar_size  <= '0;
      ar_len   <= '0;
    end else if (arvalid && arready) begin
      ar_full  <= 1'b1;
      ar_addr  <= araddr;
      ar_id    <= arid;
      ar_burst <= arburst;
      ar_size  <= arsize;
      ar_len   <= arlen;
    end else if (load && !grant_write) begin
      ar_full  <= 1'b0;
    end
  end

  // AW holding register: capture on handshake, drain when write is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full  <= 1'b0;
      aw_addr  <= '0;
      aw_id    <= '0;
      aw_burst <= '0;
      aw_size  <= '0;
      aw_len   <= '0;
    end else if (awvalid && awready) begin
      aw_full  <= 1'b1;
      aw_addr  <= awaddr;
      aw_id    <= awid;
      aw_burst <= awburst;
      aw_size  <= awsize;
      aw_len   <= awlen;
    end else if (load && grant_write) begin
      aw_full  <= 1'b0;
    end
  end

  // W holding register: one beat paired with one AW, drained with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_full <= 1'b0;
      w_data <= '0;
      w_strb <= '0;
    end else if (wvalid && wready) begin
      w_full <= 1'b1;
      w_data <= wdata;
      w_strb <= wstrb;
    end else if (load && grant_write) begin
      w_full <= 1'b0;
    end
  end

  // Output register: load the winner when free, otherwise hold or empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid  <= 1'b0;
      result_arb    <= '0;
      read_or_write <= 1'b0;
      last_grant    <= !FIRST_PRIO;
    end else if (load) begin
      result_valid  <= 1'b1;
      result_arb    <= grant_write ? write_word : read_word;
      read_or_write <= grant_write;
      last_grant    <= grant_write;
    end else if (out_free) begin
      result_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_request_arbiter.sv
// tb_request_arbiter: directed scenarios with hand-computed expectations.
module tb_request_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  araddr = '0;
  logic [3:0]   arid = '0;
  logic [1:0]   arburst = '0;
  logic [2:0]   arsize = '0;
  logic [7:0]   arlen = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  awaddr = '0;
  logic [3:0]   awid = '0;
  logic [1:0]   awburst = '0;
  logic [2:0]   awsize = '0;
  logic [7:0]   awlen = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [63:0]  wdata = '0;
  logic [7:0]   wstrb = '0;
  logic         result_valid;
  logic         result_ready = 1'b0;
  logic [127:0] result_arb;
  logic         read_or_write;

  int vectors = 0;
  int miscompares = 0;

  request_arbiter #(.FIRST_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arburst(arburst), .arsize(arsize), .arlen(arlen),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awburst(awburst), .awsize(awsize), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_arb(result_arb), .read_or_write(read_or_write)
  );

  // Posedges at 5, 15, ...; the bench drives and samples on negedges.
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; result_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    vectors++;
    if ({arready, awready, wready} !== 3'b111) begin
      miscompares++;
      $display("[TB] FAIL reset_ready got %b expected 111", {arready, awready, wready});
    end
    vectors++;
    if (result_valid !== 1'b0 || read_or_write !== 1'b0 || result_arb !== 128'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_output got v=%b rw=%b arb=%h expected all zero",
               result_valid, read_or_write, result_arb);
    end
  endtask

  task automatic test_lone_read();
    logic [127:0] exp;
    exp = {79'd0, 32'h0000_1238, 4'h3, 2'b01, 3'd3, 8'd0};
    apply_reset();
    @(negedge clk);
    result_ready = 1'b1;
    arvalid = 1'b1; araddr = 32'h0000_1238; arid = 4'h3;
    arburst = 2'b01; arsize = 3'd3; arlen = 8'd0;
    @(negedge clk);
    arvalid = 1'b0;
    vectors++;
    if (arready !== 1'b0 || result_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL read_capture got arready=%b valid=%b expected 0 0", arready, result_valid);
    end
    @(negedge clk);
    vectors++;
    if (result_valid !== 1'b1 || read_or_write !== 1'b0 || result_arb !== exp) begin
      miscompares++;
      $display("[TB] FAIL read_result got v=%b rw=%b arb=%h expected 1 0 %h",
               result_valid, read_or_write, result_arb, exp);
    end
    vectors++;
    if (arready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL read_ready_back got %b expected 1", arready);
    end
    @(negedge clk);
    vectors++;
    if (result_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL read_drain got %b expected 0", result_valid);
    end
  endtask

  task automatic test_write_aw_first();
    logic [127:0] exp;
    exp = {7'd0, 32'hDEAD_BEE8, 4'h5, 2'b01, 3'd3, 8'd0,
           64'h0123_4567_89AB_CDEF, 8'hFF};
    apply_reset();
    @(negedge clk);
    result_ready = 1'b1;
    awvalid = 1'b1; awaddr = 32'hDEAD_BEE8; awid = 4'h5;
    awburst = 2'b01; awsize = 3'd3; awlen = 8'd0;
    @(negedge clk);
    awvalid = 1'b0;
    vectors++;
    if (awready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL aw_held got awready=%b expected 0", awready);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (result_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL aw_alone_no_result cycle %0d got %b expected 0", i, result_valid);
      end
    end
    wvalid = 1'b1; wdata = 64'h0123_4567_89AB_CDEF; wstrb = 8'hFF;
    @(negedge clk);
    wvalid = 1'b0;
    vectors++;
    if (result_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL write_latency got %b expected 0", result_valid);
    end
    @(negedge clk);
    vectors++;
    if (result_valid !== 1'b1 || read_or_write !== 1'b1 || result_arb !== exp) begin
      miscompares++;
      $display("[TB] FAIL write_result got v=%b rw=%b arb=%h expected 1 1 %h",
               result_valid, read_or_write, result_arb, exp);
    end
  endtask

  task automatic test_tie_alternation();
    logic [31:0] cur_raddr;
    logic [31:0] cur_waddr;
    logic [31:0] exp_addr;
    logic        exp_rw;
    apply_reset();
    cur_raddr = 32'h1000_0000;
    cur_waddr = 32'h2000_0000;
    @(negedge clk);
    result_ready = 1'b1;
    arvalid = 1'b1; araddr = cur_raddr; arid = 4'h1;
    arburst = 2'b01; arsize = 3'd2; arlen = 8'd0;
    awvalid = 1'b1; awaddr = cur_waddr; awid = 4'h2;
    awburst = 2'b01; awsize = 3'd2; awlen = 8'd0;
    wvalid = 1'b1; wdata = 64'hAAAA_5555_AAAA_5555; wstrb = 8'h0F;
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp_rw = k[0];
      exp_addr = exp_rw ? cur_waddr : cur_raddr;
      vectors++;
      if (result_valid !== 1'b1 || read_or_write !== exp_rw ||
          (exp_rw ? result_arb[120:89] : result_arb[48:17]) !== exp_addr) begin
        miscompares++;
        $display("[TB] FAIL tie_grant %0d got v=%b rw=%b arb=%h expected rw=%b addr=%h",
                 k, result_valid, read_or_write, result_arb, exp_rw, exp_addr);
      end
      if (k < 3) begin
        result_ready = 1'b0;
        if (exp_rw) begin
          cur_waddr = cur_waddr + 32'h10;
          awvalid = 1'b1; awaddr = cur_waddr;
          wvalid = 1'b1;
        end else begin
          cur_raddr = cur_raddr + 32'h10;
          arvalid = 1'b1; araddr = cur_raddr;
        end
        @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        result_ready = 1'b1;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] exp_w;
    logic [127:0] exp_r;
    exp_w = {7'd0, 32'hCAFE_0040, 4'h7, 2'b10, 3'd1, 8'd3,
             64'hFEDC_BA98_7654_3210, 8'h3C};
    exp_r = {79'd0, 32'h0000_0ABC, 4'h9, 2'b00, 3'd0, 8'd7};
    apply_reset();
    @(negedge clk);
    result_ready = 1'b0;
    awvalid = 1'b1; awaddr = 32'hCAFE_0040; awid = 4'h7;
    awburst = 2'b10; awsize = 3'd1; awlen = 8'd3;
    wvalid = 1'b1; wdata = 64'hFEDC_BA98_7654_3210; wstrb = 8'h3C;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    arvalid = 1'b1; araddr = 32'h0000_0ABC; arid = 4'h9;
    arburst = 2'b00; arsize = 3'd0; arlen = 8'd7;
    @(negedge clk);
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if (result_valid !== 1'b1 || read_or_write !== 1'b1 ||
          result_arb !== exp_w || arready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall_hold cycle %0d got v=%b rw=%b arb=%h arready=%b expected 1 1 %h 0",
                 i, result_valid, read_or_write, result_arb, arready, exp_w);
      end
    end
    result_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (result_valid !== 1'b1 || read_or_write !== 1'b0 || result_arb !== exp_r) begin
      miscompares++;
      $display("[TB] FAIL stall_release got v=%b rw=%b arb=%h expected 1 0 %h",
               result_valid, read_or_write, result_arb, exp_r);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    @(negedge clk);
    result_ready = 1'b1;
    arvalid = 1'b1; araddr = 32'h0000_0100; arid = 4'h4;
    awvalid = 1'b1; awaddr = 32'h0000_0200; awid = 4'h6;
    wvalid = 1'b1; wdata = 64'h1; wstrb = 8'h01;
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if (result_valid !== 1'b1 || read_or_write !== 1'b0 || result_arb[48:17] !== 32'h0000_0100) begin
      miscompares++;
      $display("[TB] FAIL b2b_first got v=%b rw=%b arb=%h expected read of 00000100",
               result_valid, read_or_write, result_arb);
    end
    @(negedge clk);
    vectors++;
    if (result_valid !== 1'b1 || read_or_write !== 1'b1 || result_arb[120:89] !== 32'h0000_0200) begin
      miscompares++;
      $display("[TB] FAIL b2b_second got v=%b rw=%b arb=%h expected write of 00000200",
               result_valid, read_or_write, result_arb);
    end
    @(negedge clk);
    vectors++;
    if (result_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_drain got %b expected 0", result_valid);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    @(negedge clk);
    result_ready = 1'b0;
    arvalid = 1'b1; araddr = 32'h0000_0300; arid = 4'h2;
    awvalid = 1'b1; awaddr = 32'h0BAD_0000; awid = 4'hE;
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if (result_valid !== 1'b1 || awready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_setup got v=%b awready=%b expected 1 0", result_valid, awready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (result_valid !== 1'b0 || result_arb !== 128'h0 || read_or_write !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_clear got v=%b rw=%b arb=%h expected all zero",
               result_valid, read_or_write, result_arb);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL post_reset_ready got aw=%b ar=%b expected 1 1", awready, arready);
    end
    @(negedge clk);
    result_ready = 1'b1;
    wvalid = 1'b1; wdata = 64'h5; wstrb = 8'h80;
    @(negedge clk);
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (result_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stale_aw cycle %0d got v=%b arb=%h expected no result",
                 i, result_valid, result_arb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lone_read();
    test_write_aw_first();
    test_tie_alternation();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/request_arbiter.md
Name: request_arbiter

Overview:
- Upstream stage of the cache front end. Accepts AXI4 read-address (AR), write-address (AW) and write-data (W) requests and arbitrates between read and write traffic round-robin.
- Packs the winning request into the 128-bit result_arb word plus a read_or_write flag. The decoder stage consumes both.
- Each channel has a one-entry holding register; the result is a one-entry registered output with valid/ready handshake.

Parameters:
- FIRST_PRIO, 1'b0, direction that wins the first read/write tie after reset (0 = read, 1 = write).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- arvalid  in  1  read-address valid.
- arready  out  1  read-address ready.
- araddr  in  32  read address.
- arid  in  4  read ID.
- arburst  in  2  read burst type.
- arsize  in  3  read beat size.
- arlen  in  8  read burst length.
- awvalid  in  1  write-address valid.
- awready  out  1  write-address ready.
- awaddr  in  32  write address.
- awid  in  4  write ID.
- awburst  in  2  write burst type.
- awsize  in  3  write beat size.
- awlen  in  8  write burst length.
- wvalid  in  1  write-data valid.
- wready  out  1  write-data ready.
- wdata  in  64  write data.
- wstrb  in  8  write byte strobes.
- result_valid  out  1  result_arb and read_or_write hold a request.
- result_ready  in  1  downstream accepts the result.
- result_arb  out  128  packed request.
- read_or_write  out  1  0 = read, 1 = write.

Behaviour:
- Holding registers:
  - One entry each for AR, AW and W, with flags ar_full, aw_full, w_full.
  - arready = !ar_full, awready = !aw_full, wready = !w_full, purely from the flags. No same-cycle refill, so per-channel throughput is one request every 2 cycles.
  - A handshake (valid && ready) at an edge captures the payload and sets the flag.
- Eligibility:
  - read_elig = ar_full.
  - write_elig = aw_full && w_full. AW and W may arrive in either order or the same cycle; one W beat pairs with one AW.
- Load condition:
  - out_free = !result_valid || result_ready.
  - At an edge with out_free and any eligible request, the output register loads the grant.
  - result_valid = 1 after that edge, and the granted holding flag(s) clear at the same edge.
  - If out_free and nothing is eligible, result_valid clears at that edge.
- Grant:
  - Only one side eligible: that side wins.
  - Both eligible: the side opposite last_grant wins.
  - last_grant updates to the winner on each load; its reset value is !FIRST_PRIO.
- Packing, read (read_or_write = 0):
  - [48:17] addr, [16:13] id, [12:11] burst, [10:8] size, [7:0] len.
  - [127:49] = 0.
- Packing, write (read_or_write = 1):
  - [120:89] addr, [88:85] id, [84:83] burst, [82:80] size, [79:72] len, [71:8] wdata, [7:0] wstrb.
  - [127:121] = 0.
- Latency:
  - Handshake at edge E0, result_valid high after E1 with an idle output.
  - For a write, E0 is the later of the AW and W handshakes.
- Backpressure:
  - While result_valid && !result_ready, result_arb and read_or_write are held bit-stable.
  - Holding registers keep their data, and their ready signals stay low while full.
- Simultaneous events:
  - Output consumed and a new grant at the same edge: back-to-back results, no bubble.
  - A channel handshake may occur at the same edge another channel is granted.
- No payload transformation or checking: burst, size and len pass unmodified. Multi-beat W bursts are out of scope; one W beat per AW.
- Reset (rst_n low, any time, including mid-handshake):
  - Immediately clears ar_full, aw_full, w_full and result_valid to 0.
  - result_arb resets to 128'h0, read_or_write to 0, last_grant to !FIRST_PRIO.
  - arready, awready and wready read 1 after reset deasserts. Pending contents are dropped.

Test Plan:
- Lone read:
  - Stimulus: araddr=32'h0000_1238, arid=4'h3, arburst=2'b01, arsize=3'd3, arlen=8'd0, result_ready=1.
  - Response: 2 edges later result_valid=1, read_or_write=0, result_arb[48:17]=32'h0000_1238, [16:13]=4'h3, [12:11]=2'b01, [10:8]=3'd3, [127:49]=0. arready low for exactly 1 cycle.
- Write, AW leading W by 3 cycles:
  - Stimulus: awaddr=32'hDEAD_BEE8, wdata=64'h0123_4567_89AB_CDEF, wstrb=8'hFF.
  - Response: no result until the W handshake; then read_or_write=1, [120:89]=32'hDEAD_BEE8, [71:8]=64'h0123_4567_89AB_CDEF, [7:0]=8'hFF, [127:121]=0.
- Tie alternation (FIRST_PRIO=0):
  - Stimulus: read and write both eligible repeatedly, result_ready=1.
  - Response: grants alternate R, W, R, W. No request is starved for more than one grant.
- Backpressure:
  - Stimulus: result_ready=0 for 5 cycles with a write result pending and a new read captured.
  - Response: result_arb stable all 5 cycles and arready=0. When ready rises the write is consumed; the read appears on the next cycle.
- Back-to-back:
  - Stimulus: result_ready=1, with a read and a write already held.
  - Response: two results on consecutive cycles, result_valid continuously high.
- Mid-operation reset:
  - Stimulus: rst_n pulled low asynchronously, between edges, while result_valid=1 and aw_full=1.
  - Response: result_valid, result_arb and read_or_write go to 0 with no clock. After release, awready=1 and the old AW is never emitted.
